// File: rtl/store_buffer.sv
// Posted-write store buffer: aligns stores to byte lanes, queues them, drains to memory.
// Optional store-to-load forwarding is enabled by defining STORE_BUF_FWD_EN.
module store_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [31:0]              st_addr,
   input  logic [31:0]              st_data,
   input  logic                     st_sb,
   input  logic                     st_sh,
   output logic                     st_misaligned,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [3:0]               mem_be,
   input  logic [31:0]              ld_addr,
   output logic                     ld_conflict,
   output logic                     fwd_valid,
   output logic [31:0]              fwd_data,
   input  logic                     fence_req,
   output logic                     fence_done,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {ACCEPT, DRAIN} state_t;

   state_t             state, state_d;
   logic [29:0]        e_addr [DEPTH];
   logic [31:0]        e_data [DEPTH];
   logic [3:0]         e_be   [DEPTH];
   logic [DEPTH-1:0]   e_vld;
   logic [PTR_W-1:0]   head, tail;

   logic [1:0]         off;
   logic [3:0]         be_c;
   logic [31:0]        wdata_c;
   logic               mis_c;
   logic               full, empty, accept_hs, push, pop;
   logic               hit_any;
   logic               ld_unused;

   assign ld_unused = ^ld_addr[1:0];

   // Lane alignment and misalignment detection of the incoming store
   always_comb begin
      off     = st_addr[1:0];
      be_c    = 4'b1111;
      wdata_c = st_data;
      mis_c   = 1'b0;
      if (st_sb) begin
         be_c    = 4'b0001 << off;
         wdata_c = {24'd0, st_data[7:0]} << {off, 3'b000};
      end else if (st_sh) begin
         be_c    = 4'b0011 << off;
         wdata_c = {16'd0, st_data[15:0]} << {off, 3'b000};
         mis_c   = off[0];
      end else begin
         mis_c   = (off != 2'b00);
      end
   end

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign st_ready  = !full && (state == ACCEPT);
   assign accept_hs = st_valid && st_ready;
   assign push      = accept_hs && !mis_c;
   assign mem_valid = !empty;
   assign pop       = mem_valid && mem_ready;

   assign mem_addr  = {e_addr[head], 2'b00};
   assign mem_wdata = e_data[head];
   assign mem_be    = e_be[head];

   // Entry storage, pointers and occupancy; full blocks push and empty blocks pop,
   // so head and tail never address the same slot in one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            e_addr[i] <= '0;
            e_data[i] <= '0;
            e_be[i]   <= '0;
         end
         e_vld         <= '0;
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         st_misaligned <= 1'b0;
      end else begin
         st_misaligned <= accept_hs && mis_c;
         if (push) begin
            e_addr[tail] <= st_addr[31:2];
            e_data[tail] <= wdata_c;
            e_be[tail]   <= be_c;
            e_vld[tail]  <= 1'b1;
            tail         <= tail + PTR_W'(1);
         end
         if (pop) begin
            e_vld[head] <= 1'b0;
            head        <= head + PTR_W'(1);
         end
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);
      end
   end

`ifdef STORE_BUF_FWD_EN
   logic        y_full;
   logic [31:0] y_data;
`endif

   // Load hazard scan from oldest to youngest; the last match is the youngest
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx     = '0;
      hit_any = 1'b0;
`ifdef STORE_BUF_FWD_EN
      y_full  = 1'b0;
      y_data  = '0;
`endif
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head + PTR_W'(k);
         if (e_vld[idx] && (e_addr[idx] == ld_addr[31:2])) begin
            hit_any = 1'b1;
`ifdef STORE_BUF_FWD_EN
            y_full  = (e_be[idx] == 4'b1111);
            y_data  = e_data[idx];
`endif
         end
      end
   end

`ifdef STORE_BUF_FWD_EN
   assign fwd_valid   = y_full;
   assign fwd_data    = y_full ? y_data : 32'd0;
   assign ld_conflict = hit_any && !y_full;
`else
   assign fwd_valid   = 1'b0;
   assign fwd_data    = 32'd0;
   assign ld_conflict = hit_any;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACCEPT;
      else        state <= state_d;
   end

   // Fence: stop accepting, then report completion once the queue is empty
   always_comb begin
      state_d    = state;
      fence_done = 1'b0;
      case (state)
         ACCEPT: if (fence_req) state_d = DRAIN;
         DRAIN: begin
            fence_done = empty;
            if (empty) state_d = ACCEPT;
         end
         default: state_d = ACCEPT;
      endcase
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a scoreboard of expected memory writes.
module tb_store_buffer;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_valid, st_ready, st_sb, st_sh, st_misaligned;
   logic [31:0] st_addr, st_data;
   logic        mem_valid, mem_ready;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] ld_addr;
   logic        ld_conflict, fwd_valid, fence_req, fence_done;
   logic [31:0] fwd_data;
   logic [2:0]  count;

   int   passed = 0;
   int   total  = 0;
   txn_t sb_q[$];

   store_buffer #(.DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
      .st_sb(st_sb), .st_sh(st_sh), .st_misaligned(st_misaligned),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .ld_addr(ld_addr), .ld_conflict(ld_conflict),
      .fwd_valid(fwd_valid), .fwd_data(fwd_data),
      .fence_req(fence_req), .fence_done(fence_done), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      txn_t t;
      t.addr = a; t.wdata = d; t.be = be;
      sb_q.push_back(t);
   endtask

   // Advance one clock; any memory handshake in this cycle is scored first
   task automatic cyc();
      txn_t t;
      #1;
      if (mem_valid && mem_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_write", {31'd0, mem_valid}, 32'd0);
         end else begin
            t = sb_q.pop_front();
            check("sb_addr", mem_addr, t.addr);
            check("sb_wdata", mem_wdata, t.wdata);
            check("sb_be", {28'd0, mem_be}, {28'd0, t.be});
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic sb, input logic sh);
      st_valid = 1'b1; st_addr = a; st_data = d; st_sb = sb; st_sh = sh;
   endtask

   initial begin
      rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_sb = 1'b0; st_sh = 1'b0;
      mem_ready = 1'b0; ld_addr = 32'hFFFF_FFF0; fence_req = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_st_ready", {31'd0, st_ready}, 32'd1);
      check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_be", {28'd0, mem_be}, 32'd0);
      check("rst_count", {29'd0, count}, 32'd0);
      check("rst_misaligned", {31'd0, st_misaligned}, 32'd0);
      check("rst_ld_conflict", {31'd0, ld_conflict}, 32'd0);
      check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
      check("rst_fwd_data", fwd_data, 32'd0);
      check("rst_fence_done", {31'd0, fence_done}, 32'd0);

      // Lane alignment and first-store latency
      drive_st(32'h103, 32'hAB, 1'b1, 1'b0);
      expect_wr(32'h100, 32'hAB00_0000, 4'b1000);
      cyc();
      st_valid = 1'b0;
      check("lat_mem_valid", {31'd0, mem_valid}, 32'd1);
      check("sb_head_addr", mem_addr, 32'h100);
      check("sb_head_be", {28'd0, mem_be}, 32'h8);
      check("sb_head_wdata", mem_wdata, 32'hAB00_0000);
      drive_st(32'h202, 32'h1234, 1'b0, 1'b1);
      expect_wr(32'h200, 32'h1234_0000, 4'b1100);
      cyc();
      st_valid = 1'b0;
      check("lane_count2", {29'd0, count}, 32'd2);
      check("lane_head_hold", mem_addr, 32'h100);
      mem_ready = 1'b1;
      repeat (2) cyc();
      mem_ready = 1'b0;
      check("lane_drained", {29'd0, count}, 32'd0);

      // Misaligned half and word stores are rejected
      drive_st(32'h101, 32'h5555, 1'b0, 1'b1);
      cyc();
      st_valid = 1'b0;
      check("mis_sh_pulse", {31'd0, st_misaligned}, 32'd1);
      check("mis_sh_count", {29'd0, count}, 32'd0);
      cyc();
      check("mis_sh_pulse_end", {31'd0, st_misaligned}, 32'd0);
      drive_st(32'h102, 32'h1111_2222, 1'b0, 1'b0);
      cyc();
      st_valid = 1'b0;
      check("mis_sw_pulse", {31'd0, st_misaligned}, 32'd1);
      check("mis_sw_count", {29'd0, count}, 32'd0);
      check("mis_sw_mem_valid", {31'd0, mem_valid}, 32'd0);
      cyc();
      check("mis_sw_pulse_end", {31'd0, st_misaligned}, 32'd0);

      // Fill to full under backpressure; no bypass while full
      for (int i = 0; i < 4; i++) begin
         drive_st(32'h400 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0);
         expect_wr(32'h400 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'b1111);
         cyc();
      end
      check("full_count", {29'd0, count}, 32'd4);
      check("full_st_ready", {31'd0, st_ready}, 32'd0);
      drive_st(32'h500, 32'h9999_9999, 1'b0, 1'b0);
      mem_ready = 1'b1;
      cyc();
      st_valid = 1'b0;
      check("full_deq_only", {29'd0, count}, 32'd3);
      check("full_ready_again", {31'd0, st_ready}, 32'd1);
      repeat (3) cyc();
      mem_ready = 1'b0;
      check("full_drained", {29'd0, count}, 32'd0);

      // Load hazard detection and forwarding
      drive_st(32'h40, 32'h5A, 1'b1, 1'b0);
      expect_wr(32'h40, 32'h5A, 4'b0001);
      cyc();
      st_valid = 1'b0;
      ld_addr = 32'h43;
      #1;
      check("ld_hit_sb", {31'd0, ld_conflict}, 32'd1);
      check("ld_hit_sb_fwd", {31'd0, fwd_valid}, 32'd0);
      ld_addr = 32'h44;
      #1;
      check("ld_miss", {31'd0, ld_conflict}, 32'd0);
      drive_st(32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0);
      expect_wr(32'h40, 32'hDEAD_BEEF, 4'b1111);
      cyc();
      st_valid = 1'b0;
      ld_addr = 32'h40;
      #1;
`ifdef STORE_BUF_FWD_EN
      check("fwd_valid", {31'd0, fwd_valid}, 32'd1);
      check("fwd_data", fwd_data, 32'hDEAD_BEEF);
      check("fwd_no_conflict", {31'd0, ld_conflict}, 32'd0);
`else
      check("nofwd_conflict", {31'd0, ld_conflict}, 32'd1);
      check("nofwd_valid", {31'd0, fwd_valid}, 32'd0);
      check("nofwd_data", fwd_data, 32'd0);
`endif
      mem_ready = 1'b1;
      repeat (2) cyc();
      mem_ready = 1'b0;
      #1;
      check("ld_after_drain", {31'd0, ld_conflict}, 32'd0);
      drive_st(32'h80, 32'h0000_0001, 1'b0, 1'b0);
      ld_addr = 32'h80;
      #1;
      check("ld_same_cycle_enq", {31'd0, ld_conflict}, 32'd0);
      expect_wr(32'h80, 32'h0000_0001, 4'b1111);
      cyc();
      st_valid = 1'b0;
      mem_ready = 1'b1;
      #1;
`ifdef STORE_BUF_FWD_EN
      check("ld_head_deq_fwd", {31'd0, fwd_valid}, 32'd1);
`else
      check("ld_head_deq", {31'd0, ld_conflict}, 32'd1);
`endif
      cyc();
      mem_ready = 1'b0;
      ld_addr = 32'hFFFF_FFF0;

      // Fence on an empty buffer
      fence_req = 1'b1;
      #1;
      check("fe0_ready", {31'd0, st_ready}, 32'd1);
      check("fe0_done", {31'd0, fence_done}, 32'd0);
      cyc();
      fence_req = 1'b0;
      check("fe1_done", {31'd0, fence_done}, 32'd1);
      check("fe1_ready", {31'd0, st_ready}, 32'd0);
      cyc();
      check("fe2_ready", {31'd0, st_ready}, 32'd1);
      check("fe2_done", {31'd0, fence_done}, 32'd0);

      // Fence with two pending stores
      drive_st(32'h600, 32'h6666_0000, 1'b0, 1'b0);
      expect_wr(32'h600, 32'h6666_0000, 4'b1111);
      cyc();
      drive_st(32'h604, 32'h6666_0004, 1'b0, 1'b0);
      expect_wr(32'h604, 32'h6666_0004, 4'b1111);
      cyc();
      st_valid = 1'b0;
      fence_req = 1'b1;
      mem_ready = 1'b1;
      cyc();
      fence_req = 1'b0;
      check("fd1_ready", {31'd0, st_ready}, 32'd0);
      check("fd1_done", {31'd0, fence_done}, 32'd0);
      check("fd1_count", {29'd0, count}, 32'd1);
      cyc();
      check("fd2_count", {29'd0, count}, 32'd0);
      check("fd2_done", {31'd0, fence_done}, 32'd1);
      check("fd2_ready", {31'd0, st_ready}, 32'd0);
      cyc();
      check("fd3_ready", {31'd0, st_ready}, 32'd1);
      mem_ready = 1'b0;

      // Reset mid-drain discards pending entries
      for (int i = 0; i < 3; i++) begin
         drive_st(32'h700 + 32'(4 * i), 32'h7777_0000 + 32'(i), 1'b0, 1'b0);
         cyc();
      end
      st_valid = 1'b0;
      check("rmd_count3", {29'd0, count}, 32'd3);
      rst_n = 1'b0;
      #1;
      check("rmd_count", {29'd0, count}, 32'd0);
      check("rmd_mem_valid", {31'd0, mem_valid}, 32'd0);
      check("rmd_st_ready", {31'd0, st_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      repeat (4) cyc();
      mem_ready = 1'b0;
      check("sb_leftover", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
